// File: rtl/alu_pkg.sv
// Shared ALU-issue definitions: ALU op codes, RV32I opcode/funct7 constants
// and the funct3-to-ALU-op mapping common to OP and OP-IMM.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLT  = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB on funct3 000 and SRA on funct3 101
  function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decode into ALU control code, operands and sideband.
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            writes_rd;
  // Register indices are consumed by the register file upstream.
  logic            unused_rs_idx;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign f7            = instr[31:25];
  assign rd            = instr[11:7];
  assign imm_i         = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s         = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u         = {instr[31:12], 12'b0};
  assign unused_rs_idx = ^instr[24:15];

  // Opcode decode; unknown opcodes fall through to an all-zero illegal bundle
  always_comb begin
    alu_op    = ALU_ADD;
    a         = '0;
    b         = '0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        a         = rs1_data;
        b         = rs2_data;
        writes_rd = 1'b1;
        alu_op    = f3_to_op(f3, f7 == F7_ALT);
        illegal   = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        a         = rs1_data;
        b         = imm_i;
        writes_rd = 1'b1;
        alu_op    = f3_to_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        if (f3 == 3'b001)
          illegal = (f7 != F7_BASE);
        else if (f3 == 3'b101)
          illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_LOAD: begin
        a         = rs1_data;
        b         = imm_i;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        a = rs1_data;
        b = imm_s;
      end
      OPC_LUI: begin
        b         = imm_u;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        a         = pc;
        b         = imm_u;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        a         = rs1_data;
        b         = rs2_data;
        is_branch = 1'b1;
        case (f3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: begin
            illegal   = 1'b1;
            is_branch = 1'b0;
          end
        endcase
      end
      OPC_JALR: begin
        a         = rs1_data;
        b         = imm_i;
        writes_rd = 1'b1;
        illegal   = (f3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_write = writes_rd && !illegal && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction and registers the ALU input
// bundle behind a single-entry valid/ready handshake.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALU_control,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic [2:0]      branch_f3,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_reg_write;
  logic            dec_is_branch;
  logic            dec_illegal;
  logic            take;

  alu_ctrl_dec #(.XLEN(XLEN)) u_dec (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_op    (dec_op),
    .a         (dec_a),
    .b         (dec_b),
    .rd        (dec_rd),
    .reg_write (dec_reg_write),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Pipeline register: reset over flush over transfer; data holds otherwise
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      out_valid   <= 1'b0;
      ALU_control <= '0;
      A           <= '0;
      B           <= '0;
      rd          <= '0;
      reg_write   <= 1'b0;
      is_branch   <= 1'b0;
      branch_f3   <= '0;
      illegal     <= 1'b0;
      pc_out      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid   <= 1'b1;
      ALU_control <= dec_op;
      A           <= dec_a;
      B           <= dec_b;
      rd          <= dec_rd;
      reg_write   <= dec_reg_write;
      is_branch   <= dec_is_branch;
      branch_f3   <= instr[14:12];
      illegal     <= dec_illegal;
      pc_out      <= pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// handshake/flush/reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, A, B, pc_out;
  logic [3:0]  ALU_control;
  logic [4:0]  rd;
  logic        reg_write, is_branch, illegal;
  logic [2:0]  branch_f3;

  alu_issue_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST_n(RST_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .pc(pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_control(ALU_control), .A(A), .B(B), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .branch_f3(branch_f3), .illegal(illegal),
    .pc_out(pc_out)
  );

  always #5 CLK = ~CLK;

  // full=0: illegal encoding inside a known opcode; only illegal/reg_write/pc checked
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b, pc;
    logic [4:0]  rd;
    logic        rw, br, ill;
    logic [2:0]  f3;
    bit          full;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND indexed by funct3; SUB/SRA are the next code up
  logic [3:0] op_by_f3 [8] = '{4'd0, 4'd5, 4'd9, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] p,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [31:0] imm_i = 32'($signed(ins[31:20]));
    logic [31:0] imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] imm_u = ins & 32'hFFFF_F000;
    bit          wb = 0;
    bit          known = 1;
    e = '{default: '0};
    e.pc = p; e.rd = ins[11:7]; e.f3 = f3; e.full = 1;
    case (opc)
      7'h33: begin
        e.a = r1; e.b = r2; wb = 1;
        e.ctrl = op_by_f3[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        e.a = r1; e.b = imm_i; wb = 1;
        e.ctrl = op_by_f3[f3] + ((f3 == 5 && f7 == 7'h20) ? 4'd1 : 4'd0);
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'h03: begin e.a = r1; e.b = imm_i; wb = 1; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      7'h37: begin e.b = imm_u; wb = 1; end
      7'h17: begin e.a = p; e.b = imm_u; wb = 1; end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1;
        e.ill = (f3 == 2 || f3 == 3);
        e.ctrl = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd9 : 4'd8;
      end
      7'h67: begin e.a = r1; e.b = imm_i; wb = 1; e.ill = (f3 != 0); end
      default: begin known = 0; e.ill = 1; end
    endcase
    if (known && e.ill) e.full = 0;
    e.rw = wb && !e.ill && (e.rd != 0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, p, r1, r2, input logic [3:0] c,
                              input logic [31:0] a, b, input logic [4:0] d,
                              input logic rw, br, input logic [2:0] f3,
                              input logic ill, input bit full);
    vec_t v;
    v.instr = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.e = '{ctrl: c, a: a, b: b, pc: p, rd: d, rw: rw, br: br, ill: ill, f3: f3, full: full};
    return v;
  endfunction

  task automatic check_bundle(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".illegal"},   32'(illegal),   32'(e.ill));
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
    chk({tag, ".pc_out"},    pc_out,         e.pc);
    if (e.full) begin
      chk({tag, ".ALU_control"}, 32'(ALU_control), 32'(e.ctrl));
      chk({tag, ".A"},           A,                e.a);
      chk({tag, ".B"},           B,                e.b);
      chk({tag, ".rd"},          32'(rd),          32'(e.rd));
      chk({tag, ".is_branch"},   32'(is_branch),   32'(e.br));
      if (e.br) chk({tag, ".branch_f3"}, 32'(branch_f3), 32'(e.f3));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"},   32'(out_valid),   32'd0);
    chk({tag, ".ALU_control"}, 32'(ALU_control), 32'd0);
    chk({tag, ".A"},           A,                32'd0);
    chk({tag, ".B"},           B,                32'd0);
    chk({tag, ".rd"},          32'(rd),          32'd0);
    chk({tag, ".reg_write"},   32'(reg_write),   32'd0);
    chk({tag, ".is_branch"},   32'(is_branch),   32'd0);
    chk({tag, ".branch_f3"},   32'(branch_f3),   32'd0);
    chk({tag, ".illegal"},     32'(illegal),     32'd0);
    chk({tag, ".pc_out"},      pc_out,           32'd0);
    chk({tag, ".in_ready"},    32'(in_ready),    32'd1);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, p, r1, r2, input logic ordy);
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2; out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    logic [6:0]  opcs [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h67};
    int unsigned k = $urandom_range(0, 9);
    int unsigned f = $urandom_range(0, 3);
    if (k < 8) ins[6:0] = opcs[k];
    else if (k == 9) ins = '0;
    if (f < 2) ins[31:25] = 7'h00;
    else if (f == 2) ins[31:25] = 7'h20;
    if (k == 7 && f != 3) ins[14:12] = 3'b000;
    return ins;
  endfunction

  vec_t tbl[$];
  exp_t q[$];

  initial begin
    exp_t e1, e2;
    bit   accept, did_rst;

    tbl.push_back(mk(32'h002081B3, 32'h100, 5, 7, 4'h0, 5, 7, 3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(32'h402081B3, 32'h104, 5, 7, 4'h1, 5, 7, 3, 1, 0, 0, 0, 1));
    // srai x1,x2,3: B is the unmasked I-immediate 0x403, shamt B[4:0]=3
    tbl.push_back(mk(32'h40315093, 32'h108, 32'h80000000, 0, 4'h7, 32'h80000000, 32'h403, 1, 1, 0, 5, 0, 1));
    tbl.push_back(mk(32'h422081B3, 32'h10C, 5, 7, 4'h0, 0, 0, 3, 0, 0, 0, 1, 0));
    tbl.push_back(mk(32'h0020E063, 32'h110, 1, 32'hFFFFFFFF, 4'h8, 1, 32'hFFFFFFFF, 0, 0, 1, 6, 0, 1));
    tbl.push_back(mk(32'h00000000, 32'h114, 32'hAAAA, 32'hBBBB, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(32'h123452B7, 32'h118, 9, 9, 4'h0, 0, 32'h12345000, 5, 1, 0, 0, 0, 1));
    tbl.push_back(mk(32'hFFFFF317, 32'h11C, 9, 9, 4'h0, 32'h11C, 32'hFFFFF000, 6, 1, 0, 0, 0, 1));
    tbl.push_back(mk(32'hFE20AE23, 32'h120, 32'h1000, 32'h55, 4'h0, 32'h1000, 32'hFFFFFFFC, 5'h1C, 0, 0, 2, 0, 1));
    tbl.push_back(mk(32'h0080A003, 32'h124, 32'h2000, 0, 4'h0, 32'h2000, 8, 0, 0, 0, 2, 0, 1));
    tbl.push_back(mk(32'hFFF100E7, 32'h128, 32'h3000, 0, 4'h0, 32'h3000, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(32'h40311093, 32'h12C, 1, 1, 4'h0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(32'h0020A063, 32'h130, 1, 2, 4'h0, 0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(32'h0020D063, 32'h134, 7, 8, 4'h9, 7, 8, 0, 0, 1, 5, 0, 1));
    tbl.push_back(mk(32'hFFF13093, 32'h138, 4, 0, 4'h8, 4, 32'hFFFFFFFF, 1, 1, 0, 3, 0, 1));
    tbl.push_back(mk(32'h007362B3, 32'h13C, 32'hF0, 32'h0F, 4'h3, 32'hF0, 32'h0F, 5, 1, 0, 6, 0, 1));

    RST_n = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    chk_reset_state("reset");
    RST_n = 1'b1;

    // Directed decode table, back-to-back with out_ready held high
    foreach (tbl[i]) begin
      drive(1, tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, 1);
      @(negedge CLK);
      check_bundle($sformatf("vec%0d", i), tbl[i].e);
    end
    in_valid = 0;
    @(negedge CLK);
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: entry held for three cycles, next one follows release
    drive(1, 32'h002081B3, 32'h200, 5, 7, 1);
    e1 = ref_model(32'h002081B3, 32'h200, 5, 7);
    @(negedge CLK);
    check_bundle("bp.first", e1);
    drive(1, 32'h402081B3, 32'h204, 9, 4, 0);
    e2 = ref_model(32'h402081B3, 32'h204, 9, 4);
    #1 chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_bundle($sformatf("bp.hold%0d", i), e1);
      chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    #1 chk("bp.in_ready_rel", 32'(in_ready), 32'd1);
    @(negedge CLK);
    check_bundle("bp.second", e2);
    in_valid = 0;
    @(negedge CLK);
    chk("bp.no_dup", 32'(out_valid), 32'd0);

    // Flush with a live entry and a same-cycle input transfer
    drive(1, 32'h123452B7, 32'h300, 0, 0, 1);
    @(negedge CLK);
    check_bundle("fl.pre", ref_model(32'h123452B7, 32'h300, 0, 0));
    drive(1, 32'hFFFFF317, 32'h304, 0, 0, 1);
    flush = 1;
    @(negedge CLK);
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    flush = 0;
    in_valid = 0;
    @(negedge CLK);
    chk("fl.stays_empty", 32'(out_valid), 32'd0);
    chk("fl.pc_not_loaded", pc_out, 32'h300);

    // Reset mid-stream, then an undefined opcode
    drive(1, 32'hFFF100E7, 32'h400, 32'h3000, 0, 0);
    @(negedge CLK);
    check_bundle("rst.pre", ref_model(32'hFFF100E7, 32'h400, 32'h3000, 0));
    RST_n = 0;
    @(negedge CLK);
    chk_reset_state("rst.mid");
    RST_n = 1;
    drive(1, 32'h00000000, 32'h500, 32'h1234, 32'h5678, 1);
    @(negedge CLK);
    check_bundle("undef", ref_model(32'h00000000, 32'h500, 32'h1234, 32'h5678));
    in_valid = 0;
    @(negedge CLK);

    // Randomized traffic against a queue-of-accepted-entries model
    did_rst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (did_rst) chk_reset_state("rnd.reset");
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check_bundle("rnd", q[0]);
      RST_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      pc        = $urandom & 32'hFFFF_FFFC;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      #1 chk("rnd.in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      did_rst = !RST_n;
      if (!RST_n || flush) begin
        q.delete();
      end else begin
        accept = in_valid && (q.size() == 0 || out_ready);
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (accept) q.push_back(ref_model(instr, pc, rs1_data, rs2_data));
      end
      @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
